// File: rtl/note_player_if.sv
// Note-code write channel: 8-bit code offered with a valid/ready handshake.
interface note_player_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/note_player.sv
// Queued square-wave note player: FIFO of note codes, each played for a fixed
// duration followed by a silent gap; preempt mode replaces the queue live.
module note_player #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NOTE_CYC = 12_500_000,
  parameter int unsigned GAP_CYC  = 1_250_000,
  parameter int unsigned HALF_W   = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  note_player_if.slave            bus,
  input  logic                    mode,
  output logic                    piano_out,
  output logic                    busy,
  output logic [7:0]              cur_note,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned DMAX = (NOTE_CYC > GAP_CYC) ? NOTE_CYC : GAP_CYC;
  localparam int unsigned DW   = $clog2(DMAX + 1);

  // Mid-octave half periods in clock cycles.
  localparam int unsigned H_C = CLK_HZ / (2 * 262);
  localparam int unsigned H_D = CLK_HZ / (2 * 294);
  localparam int unsigned H_E = CLK_HZ / (2 * 330);
  localparam int unsigned H_F = CLK_HZ / (2 * 349);
  localparam int unsigned H_G = CLK_HZ / (2 * 392);
  localparam int unsigned H_A = CLK_HZ / (2 * 440);
  localparam int unsigned H_B = CLK_HZ / (2 * 494);

  typedef enum logic [1:0] {IDLE, LOAD, TONE, GAP} state_t;

  state_t            state_q, state_n;
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_n, wr_ptr_q, wr_n;
  logic [LW-1:0]     level_n;
  logic [7:0]        pend_q, pend_n;
  logic [HALF_W-1:0] half_q, half_n;
  logic [HALF_W-1:0] ph_q, ph_n;
  logic [DW-1:0]     dur_q, dur_n;
  logic              piano_n, busy_n, ovf_n;
  logic [7:0]        cur_n;
  logic              full, din_ready_c, push, pop, preempt;

  // Half period for a code: note selects the pitch, octave scales it.
  function automatic logic [HALF_W-1:0] half_lookup(input logic [5:0] code);
    logic [HALF_W-1:0] h;
    case (code[3:0])
      4'd1:    h = HALF_W'(H_C);
      4'd2:    h = HALF_W'(H_D);
      4'd3:    h = HALF_W'(H_E);
      4'd4:    h = HALF_W'(H_F);
      4'd5:    h = HALF_W'(H_G);
      4'd6:    h = HALF_W'(H_A);
      4'd7:    h = HALF_W'(H_B);
      default: h = '0;
    endcase
    case (code[5:4])
      2'd0:    h = h << 1;
      2'd2:    h = h >> 1;
      default: h = h;
    endcase
    return h;
  endfunction

  function automatic logic is_rest(input logic [3:0] n);
    return (n == 4'd0) || n[3];
  endfunction

  assign full          = (level == LW'(DEPTH));
  assign din_ready_c   = mode | ~full;
  assign bus.din_ready = din_ready_c;

  // Next-state, FIFO control and registered-output values.
  always_comb begin
    state_n = state_q;
    rd_n    = rd_ptr_q;
    wr_n    = wr_ptr_q;
    pend_n  = pend_q;
    half_n  = half_q;
    ph_n    = ph_q;
    dur_n   = dur_q;
    piano_n = piano_out;
    cur_n   = cur_note;
    ovf_n   = ovf | (bus.din_valid & ~din_ready_c);
    preempt = mode & bus.din_valid;
    push    = bus.din_valid & ~mode & ~full;
    pop     = 1'b0;
    level_n = level;
    busy_n  = busy;

    case (state_q)
      IDLE: begin
        piano_n = 1'b0;
        cur_n   = '0;
        if (level != '0) begin
          pop     = 1'b1;
          pend_n  = mem[rd_ptr_q];
          rd_n    = rd_ptr_q + AW'(1);
          state_n = LOAD;
        end
      end
      LOAD: begin
        cur_n   = pend_q;
        half_n  = half_lookup(pend_q[5:0]);
        ph_n    = '0;
        dur_n   = '0;
        piano_n = ~is_rest(pend_q[3:0]);
        state_n = TONE;
      end
      TONE: begin
        if (dur_q == DW'(NOTE_CYC - 1)) begin
          dur_n   = '0;
          ph_n    = '0;
          piano_n = 1'b0;
          if (GAP_CYC == 0) begin
            state_n = IDLE;
            cur_n   = '0;
          end else begin
            state_n = GAP;
          end
        end else begin
          dur_n = dur_q + DW'(1);
          if (ph_q == half_q - HALF_W'(1)) begin
            ph_n    = '0;
            piano_n = ~piano_out & ~is_rest(cur_note[3:0]);
          end else begin
            ph_n = ph_q + HALF_W'(1);
          end
        end
      end
      GAP: begin
        piano_n = 1'b0;
        if (dur_q == DW'(GAP_CYC - 1)) begin
          dur_n   = '0;
          cur_n   = '0;
          state_n = IDLE;
        end else begin
          dur_n = dur_q + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (push) wr_n = wr_ptr_q + AW'(1);
    level_n = level + LW'(push) - LW'(pop);

    // A preempting write flushes the queue, cancels any pop and idles the player.
    if (preempt) begin
      rd_n    = '0;
      wr_n    = AW'(1);
      level_n = LW'(1);
      state_n = IDLE;
      piano_n = 1'b0;
      cur_n   = '0;
      dur_n   = '0;
      ph_n    = '0;
    end

    busy_n = (state_n != IDLE) || (level_n != '0);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level     <= '0;
      pend_q    <= '0;
      half_q    <= '0;
      ph_q      <= '0;
      dur_q     <= '0;
      piano_out <= 1'b0;
      cur_note  <= '0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_q   <= state_n;
      rd_ptr_q  <= rd_n;
      wr_ptr_q  <= wr_n;
      level     <= level_n;
      pend_q    <= pend_n;
      half_q    <= half_n;
      ph_q      <= ph_n;
      dur_q     <= dur_n;
      piano_out <= piano_n;
      cur_note  <= cur_n;
      busy      <= busy_n;
      ovf       <= ovf_n;
    end
  end

  // FIFO storage; a preempting write lands in slot 0.
  always_ff @(posedge clk) begin
    if (preempt) begin
      mem[0] <= bus.din;
    end else if (push) begin
      mem[wr_ptr_q] <= bus.din;
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed scenarios plus random traffic, every cycle
// compared against a queue-and-age reference model.
module tb_note_player;
  localparam int unsigned CLK_HZ   = 100_000;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned NOTE_CYC = 1000;
  localparam int unsigned GAP_CYC  = 100;
  localparam int unsigned HALF_W   = 18;
  localparam int          LW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic          piano_out, busy, ovf;
  logic [7:0]    cur_note;
  logic [LW-1:0] level;

  note_player_if bus_if ();

  note_player #(
    .CLK_HZ(CLK_HZ), .DEPTH(DEPTH), .NOTE_CYC(NOTE_CYC),
    .GAP_CYC(GAP_CYC), .HALF_W(HALF_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .mode(mode),
    .piano_out(piano_out), .busy(busy), .cur_note(cur_note),
    .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Half period from the note table: f_mid list, low doubles, high halves.
  function automatic int half_of(input logic [7:0] code);
    int f, h;
    case (code[3:0])
      4'd1: f = 262;  4'd2: f = 294;  4'd3: f = 330;  4'd4: f = 349;
      4'd5: f = 392;  4'd6: f = 440;  4'd7: f = 494;
      default: f = 0;
    endcase
    if (f == 0) return 0;
    h = CLK_HZ / (2 * f);
    if (code[5:4] == 2'd0) h = h * 2;
    else if (code[5:4] == 2'd2) h = h / 2;
    return h;
  endfunction

  // Reference model: a queue of codes and the age of the note being played.
  logic [7:0] mq[$];
  bit         m_play = 1'b0;
  logic [7:0] m_code = '0;
  int         m_age  = 0;
  bit         m_ovf  = 1'b0;

  always @(posedge clk) begin
    int sz;
    bit was_idle;
    if (rst) begin
      mq.delete();
      m_play = 1'b0;
      m_age  = 0;
      m_code = '0;
      m_ovf  = 1'b0;
    end else begin
      sz       = mq.size();
      was_idle = !m_play;
      if (m_play) begin
        m_age++;
        if (m_age == NOTE_CYC + GAP_CYC + 1) m_play = 1'b0;
      end
      if (mode && bus_if.din_valid) begin
        mq.delete();
        mq.push_back(bus_if.din);
        m_play = 1'b0;
      end else begin
        if (was_idle && sz > 0) begin
          m_code = mq.pop_front();
          m_play = 1'b1;
          m_age  = 0;
        end
        if (bus_if.din_valid) begin
          if (sz < DEPTH) mq.push_back(bus_if.din);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  function automatic logic exp_piano();
    int h;
    if (!m_play || m_age < 1 || m_age > NOTE_CYC) return 1'b0;
    h = half_of(m_code);
    if (h == 0) return 1'b0;
    return (((m_age - 1) / h) % 2) == 0;
  endfunction

  // Compare all outputs against the model just after each active edge.
  always @(posedge clk) begin
    logic [14:0] got, exp;
    #1;
    got = {piano_out, busy, cur_note, level, ovf, bus_if.din_ready};
    exp = {exp_piano(), (m_play || mq.size() > 0),
           ((m_play && m_age >= 1) ? m_code : 8'h00),
           LW'(mq.size()), m_ovf, (mode || mq.size() < DEPTH)};
    check("outs", 32'(got), 32'(exp));
  end

  task automatic wait_piano(input logic val, input int max, output int n);
    n = 0;
    while (piano_out !== val && n < max) begin @(negedge clk); n++; end
  endtask

  task automatic wait_note(input logic [7:0] code, input int max, output int n);
    n = 0;
    while (cur_note !== code && n < max) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle(input int max, output int n);
    n = 0;
    while (busy !== 1'b0 && n < max) begin @(negedge clk); n++; end
  endtask

  // Offer one code for one cycle; called at a negedge, returns at the next.
  task automatic send(input logic [7:0] code);
    bus_if.din = code;
    bus_if.din_valid = 1'b1;
    @(negedge clk);
    bus_if.din_valid = 1'b0;
  endtask

  initial begin
    int n, h, l, hi;
    bit saw10, saw1f;
    logic [7:0] c [5];

    rst = 1'b1;
    mode = 1'b0;
    bus_if.din = '0;
    bus_if.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_level", 32'(level), 0);
    check("rst_piano", 32'(piano_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_note", 32'(cur_note), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single mid A: rise 2 cycles after accept, 113-cycle halves, 1100 total.
    send(8'h16);
    check("s1_level", 32'(level), 1);
    wait_piano(1'b1, 10, n);
    check("s1_rise", 32'(n), 2);
    wait_piano(1'b0, 500, h);
    check("s1_high", 32'(h), 113);
    wait_piano(1'b1, 500, l);
    check("s1_low", 32'(l), 113);
    wait_idle(2000, n);
    check("s1_busy_drop", 32'(h + l + n), NOTE_CYC + GAP_CYC);

    // Three queued notes, spacing NOTE+GAP+2.
    bus_if.din_valid = 1'b1;
    bus_if.din = 8'h06; @(negedge clk);
    bus_if.din = 8'h26; @(negedge clk);
    bus_if.din = 8'h11; @(negedge clk);
    bus_if.din_valid = 1'b0;
    wait_note(8'h06, 10, n);
    check("s2_note0", 32'(cur_note), 32'h06);
    wait_piano(1'b0, 500, h);
    check("s2_half0", 32'(h), 226);
    wait_note(8'h26, 2000, n);
    check("s2_space0", 32'(h + n), NOTE_CYC + GAP_CYC + 2);
    wait_piano(1'b0, 500, h);
    check("s2_half1", 32'(h), 56);
    wait_note(8'h11, 2000, n);
    check("s2_space1", 32'(h + n), NOTE_CYC + GAP_CYC + 2);
    wait_piano(1'b0, 500, h);
    check("s2_half2", 32'(h), 190);
    wait_idle(2000, n);

    // Five back-to-back random codes fill the FIFO; a sixth overflows.
    begin
      int r;
      r = $urandom_range(0, 6);
      for (int i = 0; i < 5; i++)
        c[i] = {2'b00, 2'($urandom_range(0, 3)), 4'(((i + r) % 7) + 1)};
    end
    bus_if.din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin bus_if.din = c[i]; @(negedge clk); end
    bus_if.din_valid = 1'b0;
    check("s3_full_level", 32'(level), DEPTH);
    check("s3_ready_low", 32'(bus_if.din_ready), 0);
    send(8'h37);
    check("s3_ovf", 32'(ovf), 1);
    check("s3_level_kept", 32'(level), DEPTH);
    for (int i = 0; i < 5; i++) begin
      wait_note(c[i], 2500, n);
      check("s3_order", 32'(cur_note), 32'(c[i]));
    end
    wait_idle(2500, n);

    // Two rests: silence for both slots, codes still shown.
    bus_if.din_valid = 1'b1;
    bus_if.din = 8'h10; @(negedge clk);
    bus_if.din = 8'h1F; @(negedge clk);
    bus_if.din_valid = 1'b0;
    hi = 0; saw10 = 1'b0; saw1f = 1'b0;
    for (int i = 0; i < 2250; i++) begin
      hi += int'(piano_out);
      if (cur_note == 8'h10) saw10 = 1'b1;
      if (cur_note == 8'h1F && saw10) saw1f = 1'b1;
      @(negedge clk);
    end
    check("s4_silent", 32'(hi), 0);
    check("s4_saw10", 32'(saw10), 1);
    check("s4_saw1f", 32'(saw1f), 1);
    check("s4_idle", 32'(busy), 0);

    // Preempt during TONE with three notes queued.
    bus_if.din_valid = 1'b1;
    bus_if.din = 8'h13; @(negedge clk);
    bus_if.din = 8'h01; @(negedge clk);
    bus_if.din = 8'h02; @(negedge clk);
    bus_if.din = 8'h03; @(negedge clk);
    bus_if.din_valid = 1'b0;
    repeat (300) @(negedge clk);
    check("s5_playing", 32'(cur_note), 32'h13);
    check("s5_level3", 32'(level), 3);
    mode = 1'b1;
    send(8'h25);
    mode = 1'b0;
    check("s5_piano0", 32'(piano_out), 0);
    check("s5_level1", 32'(level), 1);
    check("s5_note0", 32'(cur_note), 0);
    check("s5_busy", 32'(busy), 1);
    wait_piano(1'b1, 10, n);
    check("s5_rise", 32'(n), 2);
    check("s5_note", 32'(cur_note), 32'h25);
    wait_piano(1'b0, 500, h);
    check("s5_half", 32'(h), 32'(half_of(8'h25)));
    wait_idle(1500, n);
    check("s5_idle", 32'(busy), 0);

    // Reset mid-TONE with two notes waiting.
    bus_if.din_valid = 1'b1;
    bus_if.din = 8'h14; @(negedge clk);
    bus_if.din = 8'h15; @(negedge clk);
    bus_if.din = 8'h16; @(negedge clk);
    bus_if.din_valid = 1'b0;
    repeat (100) @(negedge clk);
    check("s6_level2", 32'(level), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s6_piano", 32'(piano_out), 0);
    check("s6_level", 32'(level), 0);
    check("s6_ovf", 32'(ovf), 0);
    check("s6_busy", 32'(busy), 0);
    hi = 0;
    for (int i = 0; i < 3000; i++) begin
      hi += int'(piano_out) + int'(busy);
      @(negedge clk);
    end
    check("s6_quiet", 32'(hi), 0);

    // Random traffic against the model.
    for (int i = 0; i < 15000; i++) begin
      bus_if.din = 8'($urandom);
      bus_if.din_valid = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 499) == 0) mode = ~mode;
      @(negedge clk);
    end
    bus_if.din_valid = 1'b0;
    mode = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
